regfile_sweeper: RTL and testbench

- Master-side sequencer that drives the read and write address ports of the 32x32 register file.
- Two bulk operations:
  - CLEAR: writes a fill value to every register, one per cycle.
  - DUMP: reads every register in address order and streams out (addr, data) pairs over a valid/ready handshake.
- Used by the debug/boot path for register-file initialisation and state inspection; it is not on the core's datapath.

---
 rtl/regfile_sweeper.sv | 117 +++++++++++
 tb/tb_regfile_sweeper.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sweeper.sv
// Bulk sequencer for the 32x32 register file: CLEAR fills every register with one value,
// DUMP streams every (addr, data) pair out over a valid/ready handshake.
module regfile_sweeper #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [DATA_W-1:0] cmd_fill,
    output logic [ADDR_W-1:0] rf_A1,
    input  logic [DATA_W-1:0] rf_RD1,
    output logic [ADDR_W-1:0] rf_A3,
    output logic [DATA_W-1:0] rf_WD3,
    output logic              rf_WE3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CLEAR    = 3'd1;
    localparam logic [2:0] S_DUMP_RD  = 3'd2;
    localparam logic [2:0] S_DUMP_OUT = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    idx_d   = '0;
                    fill_d  = cmd_fill;
                    state_d = cmd_op ? S_DUMP_RD : S_CLEAR;
                end
            end
            S_CLEAR: begin
                // Terminal compare, never a wrap: idx stops at the last register.
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DUMP_RD: begin
                out_data_d  = rf_RD1;
                out_addr_d  = idx_q;
                out_valid_d = 1'b1;
                state_d     = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_DUMP_RD;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
        end
    end

    // Write port is decoded straight from state so reset kills rf_WE3 without waiting for a clock.
    assign rf_WE3    = (state_q == S_CLEAR);
    assign rf_A3     = rf_WE3 ? idx_q : '0;
    assign rf_WD3    = rf_WE3 ? fill_q : '0;
    assign rf_A1     = (state_q == S_DUMP_RD || state_q == S_DUMP_OUT) ? idx_q : '0;
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_regfile_sweeper.sv
// Randomised self-checking bench for regfile_sweeper with a behavioural 32x32 register file.
module tb_regfile_sweeper;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [31:0] cmd_fill;
    logic [4:0]  rf_A1;
    logic [31:0] rf_RD1;
    logic [4:0]  rf_A3;
    logic [31:0] rf_WD3;
    logic        rf_WE3;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [32];

    regfile_sweeper #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_fill  (cmd_fill),
        .rf_A1     (rf_A1),
        .rf_RD1    (rf_RD1),
        .rf_A3     (rf_A3),
        .rf_WD3    (rf_WD3),
        .rf_WE3    (rf_WE3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: combinational read, write on rising edge.
    assign rf_RD1 = mem[rf_A1];
    always @(posedge clk) begin
        if (rf_WE3 === 1'b1) mem[rf_A3] = rf_WD3;
    end

    // Present a command at the current negedge; returns at the first negedge after acceptance.
    task automatic issue(input logic op, input logic [31:0] f);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_fill  = f;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL issue_ready: got %b want 1", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_fill  = ~f;
    endtask

    task automatic test_reset();
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_fill = '0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({cmd_ready, busy, done, rf_WE3, out_valid} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 10000", {cmd_ready, busy, done, rf_WE3, out_valid});
        end
        n_cmp++;
        if ({rf_A1, rf_A3, rf_WD3, out_addr, out_data} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %0h want 0", {rf_A1, rf_A3, rf_WD3, out_addr, out_data});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clear(input logic [31:0] f);
        int we_cnt = 0, done_cnt = 0, done_k = 0, bad = 0;
        bit order_ok = 1, window_ok = 1;
        issue(1'b0, f);
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL clear_ready_fall: got %b want 0", cmd_ready);
        end
        for (int k = 1; k <= 40; k++) begin
            if (rf_WE3 !== (k <= 32)) window_ok = 0;
            if (rf_WE3 === 1'b1) begin
                if (rf_A3 !== we_cnt[4:0] || rf_WD3 !== f) order_ok = 0;
                we_cnt++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_k = k;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (we_cnt != 32 || !window_ok) begin
            n_err++;
            $display("FAIL clear_we_count: got %0d window_ok=%0d want 32 window_ok=1", we_cnt, window_ok);
        end
        n_cmp++;
        if (!order_ok) begin
            n_err++;
            $display("FAIL clear_order: got out-of-order write want addr 0..31 data %h", f);
        end
        n_cmp++;
        if (done_cnt != 1 || done_k != 33) begin
            n_err++;
            $display("FAIL clear_done: got %0d pulses at cycle %0d want 1 at 33", done_cnt, done_k);
        end
        for (int i = 0; i < 32; i++) if (mem[i] !== f) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL clear_mem: got %0d wrong registers want 0", bad);
        end
    endtask

    // Collect one DUMP; mode 0: out_ready tied high, mode 1: random ready plus a stall at addr 7.
    task automatic collect_dump(input int mode);
        logic [31:0] exp_data [32];
        logic [4:0]  pa = '0;
        logic [31:0] pd = '0;
        int nwords = 0, done_k = 0, stall = 0, k = 1;
        bit stalled_prev = 0, stable_ok = 1, timing_ok = 1, we_ok = 1;
        for (int i = 0; i < 32; i++) exp_data[i] = mem[i];
        while (k <= 3000 && done_k == 0) begin
            if (rf_WE3 !== 1'b0) we_ok = 0;
            if (stalled_prev && (out_valid !== 1'b1 || out_addr !== pa || out_data !== pd))
                stable_ok = 0;
            if (done === 1'b1) done_k = k;
            if (mode == 0) begin
                out_ready = 1'b1;
            end else if (out_valid === 1'b1 && out_addr === 5'd7 && stall < 20) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = ($urandom_range(0, 9) < 3);
            end
            if (out_valid === 1'b1 && out_ready) begin
                if (nwords < 32) begin
                    n_cmp++;
                    if (out_addr !== 5'(nwords) || out_data !== exp_data[nwords]) begin
                        n_err++;
                        $display("FAIL dump_word%0d: got %0h/%h want %0h/%h", nwords, out_addr,
                                 out_data, nwords, exp_data[nwords]);
                    end
                end
                if (k != 2 + 2 * nwords) timing_ok = 0;
                nwords++;
            end
            stalled_prev = (out_valid === 1'b1) && !out_ready;
            pa = out_addr;
            pd = out_data;
            @(negedge clk);
            k++;
        end
        out_ready = 1'b0;
        n_cmp++;
        if (nwords != 32 || done_k == 0) begin
            n_err++;
            $display("FAIL dump_count: got %0d words done_seen=%0d want 32 done_seen=1", nwords,
                     done_k != 0);
        end
        n_cmp++;
        if (!we_ok || !stable_ok) begin
            n_err++;
            $display("FAIL dump_stable: got we_ok=%0d stable_ok=%0d want 1 1", we_ok, stable_ok);
        end
        if (mode == 0) begin
            n_cmp++;
            if (!timing_ok || done_k != 65) begin
                n_err++;
                $display("FAIL dump_timing: got timing_ok=%0d done_at=%0d want 1 65", timing_ok,
                         done_k);
            end
        end else begin
            n_cmp++;
            if (stall != 20) begin
                n_err++;
                $display("FAIL dump_stall: got %0d stall cycles want 20", stall);
            end
        end
    endtask

    task automatic test_dump_ready();
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000 + i;
        issue(1'b1, 32'h0);
        collect_dump(0);
    endtask

    task automatic test_dump_backpressure();
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        issue(1'b1, 32'h0);
        collect_dump(1);
    endtask

    task automatic test_cmd_while_busy();
        int k = 1, bad = 0;
        logic [31:0] f = $urandom;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_fill = f;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL busy_first_ready: got %b want 1", cmd_ready);
        end
        @(negedge clk);
        cmd_op = 1'b1; cmd_fill = ~f;
        while (cmd_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k != 34) begin
            n_err++;
            $display("FAIL busy_reaccept: got ready at cycle %0d want 34", k);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 32; i++) if (mem[i] !== f) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL busy_fill: got %0d wrong registers want 0", bad);
        end
        collect_dump(0);
    endtask

    task automatic test_reset_mid_clear();
        int bad = 0;
        logic [31:0] f = 32'hA5A5_5A5A;
        for (int i = 0; i < 32; i++) mem[i] = 32'h5000 + i;
        issue(1'b0, f);
        repeat (12) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({rf_WE3, busy, done, cmd_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL rst_clear_outputs: got %b want 0001", {rf_WE3, busy, done, cmd_ready});
        end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 32; i++) if (mem[i] !== ((i < 12) ? f : 32'h5000 + i)) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL rst_clear_mem: got %0d wrong registers want 0", bad);
        end
        rst = 1'b0;
        @(negedge clk);
        test_clear(32'h1357_9BDF);
    endtask

    task automatic test_reset_mid_dump();
        int k = 0;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        issue(1'b1, 32'h0);
        out_ready = 1'b1;
        while (!(out_valid === 1'b1 && out_addr === 5'd5) && k < 200) begin
            @(negedge clk);
            k++;
        end
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_dump_pre: got out_valid %b want 1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_dump_outputs: got %b want 000", {out_valid, busy, done});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(1'b1, 32'h0);
        collect_dump(0);
    endtask

    initial begin
        test_reset();
        test_clear(32'hDEADBEEF);
        test_dump_ready();
        test_dump_backpressure();
        test_cmd_while_busy();
        test_reset_mid_clear();
        test_reset_mid_dump();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
